// File: rtl/acorn_ctrl128_if.sv
// Bundle between the ACORN-128 phase sequencer and its neighbours (host, state update, keystream).
// Latency: none, wires only.
// Backpressure: din_valid/din_ready per bit; ACORN_CTRL_DECRYPT_EN adds the dec input.
interface acorn_ctrl128_if #(parameter int LEN_W = 16);
  logic             start;
  logic [127:0]     key;
  logic [127:0]     iv;
  logic [LEN_W-1:0] ad_len;
  logic [LEN_W-1:0] msg_len;
  logic             din_valid;
  logic             din_bit;
  logic             din_ready;
  logic             ks_in;
  logic             step_en;
  logic             ca;
  logic             cb;
  logic             mbit;
  logic             dout_valid;
  logic             dout_bit;
  logic             busy;
  logic             done;
  logic [127:0]     tag;
`ifdef ACORN_CTRL_DECRYPT_EN
  logic             dec;

  modport master (
    output start, key, iv, ad_len, msg_len, din_valid, din_bit, ks_in, dec,
    input  din_ready, step_en, ca, cb, mbit, dout_valid, dout_bit, busy, done, tag
  );
  modport slave (
    input  start, key, iv, ad_len, msg_len, din_valid, din_bit, ks_in, dec,
    output din_ready, step_en, ca, cb, mbit, dout_valid, dout_bit, busy, done, tag
  );
`else
  modport master (
    output start, key, iv, ad_len, msg_len, din_valid, din_bit, ks_in,
    input  din_ready, step_en, ca, cb, mbit, dout_valid, dout_bit, busy, done, tag
  );
  modport slave (
    input  start, key, iv, ad_len, msg_len, din_valid, din_bit, ks_in,
    output din_ready, step_en, ca, cb, mbit, dout_valid, dout_bit, busy, done, tag
  );
`endif
endinterface

// File: rtl/acorn_ctrl128.sv
// ACORN-128 bit-serial phase sequencer: init, AD, padding, message, finalisation, tag capture.
// Latency: first INIT step the cycle after start; done registered one cycle after the last FIN step.
// Backpressure: AD/MSG advance only on din_valid & din_ready; fixed phases step every cycle.
// Optional decrypt mode under macro ACORN_CTRL_DECRYPT_EN (adds latched dec input).
module acorn_ctrl128 #(
  parameter int LEN_W = 16
) (
  input logic          clk,
  input logic          rst,
  acorn_ctrl128_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_ADPAD, S_MSG, S_MSGPAD, S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [10:0]      r_cnt;      // step counter for the fixed-length phases
  logic [LEN_W-1:0] r_bcnt;     // accepted-bit counter for AD/MSG
  logic [127:0]     r_key;
  logic [127:0]     r_iv;
  logic [127:0]     r_tag;
  logic [LEN_W-1:0] r_ad_len;
  logic [LEN_W-1:0] r_msg_len;
  logic             r_done;
`ifdef ACORN_CTRL_DECRYPT_EN
  logic             r_dec;
`endif

  logic [6:0] w_cnt_lo;
  logic       w_in_data;
  logic       w_hs;
  logic       w_bcnt_last;
  logic       w_ks_bit;
  logic       w_step;
  logic       w_ca;
  logic       w_cb;
  logic       w_mbit;
  logic       w_din_rdy;
  logic       w_dout_vld;
  logic       w_dout_bit;

  assign w_cnt_lo    = r_cnt[6:0];
  assign w_in_data   = (r_state == S_AD) || (r_state == S_MSG);
  assign w_hs        = w_in_data && bus.din_valid;
  assign w_bcnt_last = (r_bcnt + LEN_W'(1)) == ((r_state == S_AD) ? r_ad_len : r_msg_len);
  assign w_ks_bit    = bus.din_bit ^ bus.ks_in;

  // State register; reset aborts any operation straight to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; data phases leave on the edge accepting their final bit
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_INIT;
      S_INIT:   if (r_cnt == 11'd1791) w_next = (r_ad_len != '0) ? S_AD : S_ADPAD;
      S_AD:     if (w_hs && w_bcnt_last) w_next = S_ADPAD;
      S_ADPAD:  if (r_cnt == 11'd255) w_next = (r_msg_len != '0) ? S_MSG : S_MSGPAD;
      S_MSG:    if (w_hs && w_bcnt_last) w_next = S_MSGPAD;
      S_MSGPAD: if (r_cnt == 11'd255) w_next = S_FIN;
      S_FIN:    if (r_cnt == 11'd767) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Per-step control decode consumed by the state update on the same edge
  always_comb begin
    w_step     = 1'b0;
    w_ca       = 1'b0;
    w_cb       = 1'b0;
    w_mbit     = 1'b0;
    w_din_rdy  = 1'b0;
    w_dout_vld = 1'b0;
    w_dout_bit = 1'b0;
    case (r_state)
      S_INIT: begin
        w_step = 1'b1;
        w_ca   = 1'b1;
        w_cb   = 1'b1;
        if (r_cnt < 11'd128)       w_mbit = r_key[w_cnt_lo];
        else if (r_cnt < 11'd256)  w_mbit = r_iv[w_cnt_lo];
        else if (r_cnt == 11'd256) w_mbit = ~r_key[0];
        else                       w_mbit = r_key[w_cnt_lo];
      end
      S_AD: begin
        w_din_rdy = 1'b1;
        w_step    = bus.din_valid;
        w_mbit    = bus.din_bit;
        w_ca      = 1'b1;
        w_cb      = 1'b1;
      end
      S_ADPAD: begin
        w_step = 1'b1;
        w_mbit = (r_cnt == 11'd0);
        w_ca   = (r_cnt < 11'd128);
        w_cb   = 1'b1;
      end
      S_MSG: begin
        w_din_rdy  = 1'b1;
        w_step     = bus.din_valid;
`ifdef ACORN_CTRL_DECRYPT_EN
        // decrypting feeds the recovered plaintext back into the state
        w_mbit     = r_dec ? w_ks_bit : bus.din_bit;
`else
        w_mbit     = bus.din_bit;
`endif
        w_ca       = 1'b1;
        w_cb       = 1'b0;
        w_dout_vld = bus.din_valid;
        w_dout_bit = w_ks_bit;
      end
      S_MSGPAD: begin
        w_step = 1'b1;
        w_mbit = (r_cnt == 11'd0);
        w_ca   = (r_cnt < 11'd128);
        w_cb   = 1'b0;
      end
      S_FIN: begin
        w_step = 1'b1;
        w_ca   = 1'b1;
        w_cb   = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, operand latches, tag capture and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_key     <= '0;
      r_iv      <= '0;
      r_tag     <= '0;
      r_ad_len  <= '0;
      r_msg_len <= '0;
      r_done    <= 1'b0;
`ifdef ACORN_CTRL_DECRYPT_EN
      r_dec     <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == S_FIN) && (r_cnt == 11'd767);

      if (w_next != r_state)          r_cnt <= '0;
      else if (w_step && !w_in_data)  r_cnt <= r_cnt + 11'd1;

      if (w_next != r_state) r_bcnt <= '0;
      else if (w_hs)         r_bcnt <= r_bcnt + LEN_W'(1);

      if ((r_state == S_IDLE) && bus.start) begin
        r_key     <= bus.key;
        r_iv      <= bus.iv;
        r_ad_len  <= bus.ad_len;
        r_msg_len <= bus.msg_len;
        r_tag     <= '0;
`ifdef ACORN_CTRL_DECRYPT_EN
        r_dec     <= bus.dec;
`endif
      end

      // last 128 FIN steps: 640 is a multiple of 128, so the low bits index the tag
      if ((r_state == S_FIN) && (r_cnt >= 11'd640)) r_tag[w_cnt_lo] <= bus.ks_in;
    end
  end

  assign bus.step_en    = w_step;
  assign bus.ca         = w_ca;
  assign bus.cb         = w_cb;
  assign bus.mbit       = w_mbit;
  assign bus.din_ready  = w_din_rdy;
  assign bus.dout_valid = w_dout_vld;
  assign bus.dout_bit   = w_dout_bit;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.tag        = r_tag;

endmodule
